// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// datapath widths and default busy durations.
package md_defs;

  localparam int unsigned MD_OP_W = 3;
  localparam int unsigned MD_W    = 32;
  localparam int unsigned MD_DW   = 64;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP6  = 3'd6,
    MD_NOP7  = 3'd7
  } md_op_e;

endpackage

// File: rtl/md_unit_if.sv
// EX-stage request/result bundle between the pipeline and the muldiv unit.
interface md_unit_if;
  import md_defs::*;

  logic                start;
  logic [MD_OP_W-1:0]  op;
  logic [MD_W-1:0]     rs_val;
  logic [MD_W-1:0]     rt_val;
  logic                busy;
  logic [MD_W-1:0]     hi;
  logic [MD_W-1:0]     lo;

  modport master (output start, op, rs_val, rt_val, input busy, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, hi, lo);

endinterface

// File: rtl/md_unit_calc.sv
// Combinational MULT/MULTU/DIV/DIVU datapath producing the {hi,lo} result
// and a divide-by-zero flag for the latched operands.
module md_calc
  import md_defs::*;
(
  input  md_op_e           op_i,
  input  logic [MD_W-1:0]  a_i,
  input  logic [MD_W-1:0]  b_i,
  output logic [MD_DW-1:0] hilo_o,
  output logic             div_by_zero_o
);

  logic [MD_DW-1:0] prod_s, prod_u;
  logic [MD_W-1:0]  safe_u, mag_a, mag_b, safe_m;
  logic [MD_W-1:0]  q_u, r_u, q_m, r_m, q_s, r_s;
  logic             a_neg, b_neg;

  assign prod_s = {{MD_W{a_i[MD_W-1]}}, a_i} * {{MD_W{b_i[MD_W-1]}}, b_i};
  assign prod_u = {{MD_W{1'b0}}, a_i} * {{MD_W{1'b0}}, b_i};

  // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow case.
  assign a_neg  = a_i[MD_W-1];
  assign b_neg  = b_i[MD_W-1];
  assign mag_a  = a_neg ? -a_i : a_i;
  assign mag_b  = b_neg ? -b_i : b_i;
  assign safe_u = (b_i == '0) ? MD_W'(1) : b_i;
  assign safe_m = (mag_b == '0) ? MD_W'(1) : mag_b;

  assign q_u = a_i / safe_u;
  assign r_u = a_i % safe_u;
  assign q_m = mag_a / safe_m;
  assign r_m = mag_a % safe_m;
  assign q_s = (a_neg ^ b_neg) ? -q_m : q_m;
  assign r_s = a_neg ? -r_m : r_m;

  always_comb begin
    hilo_o        = '0;
    div_by_zero_o = 1'b0;
    case (op_i)
      MD_MULT:  hilo_o = prod_s;
      MD_MULTU: hilo_o = prod_u;
      MD_DIV: begin
        hilo_o        = {r_s, q_s};
        div_by_zero_o = (b_i == '0);
      end
      MD_DIVU: begin
        hilo_o        = {r_u, q_u};
        div_by_zero_o = (b_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy stalls
// HI/LO-dependent instructions until the result commits.
module md_unit
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [MD_W-1:0]  a_q, a_d, b_q, b_d;
  logic [MD_W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [MD_DW-1:0] calc_hilo;
  logic             calc_dbz;

  md_calc u_calc (
    .op_i          (op_q),
    .a_i           (a_q),
    .b_i           (b_q),
    .hilo_o        (calc_hilo),
    .div_by_zero_o (calc_dbz)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (md_op_e'(bus.op))
            MD_MTHI: hi_d = bus.rs_val;
            MD_MTLO: lo_d = bus.rs_val;
            MD_MULT, MD_MULTU: begin
              op_d    = md_op_e'(bus.op);
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = ST_BUSY;
            end
            MD_DIV, MD_DIVU: begin
              op_d    = md_op_e'(bus.op);
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = ST_BUSY;
            end
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (!calc_dbz) begin
            hi_d = calc_hilo[MD_DW-1:MD_W];
            lo_d = calc_hilo[MD_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.busy = (state_q == ST_BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: driver pushes model results, monitor checks
// them when the unit commits.
module tb_md_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned cyc;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  md_unit_if bus();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t        sb[$];
  int unsigned checks = 0;
  int unsigned passes = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural definition.
  function automatic logic [63:0] ref_md(int op, logic [31:0] a, logic [31:0] b,
                                         logic [31:0] chi, logic [31:0] clo);
    longint          x, y, qs, rs;
    longint unsigned ux, uy;
    logic [63:0]     res;
    res = {chi, clo};
    case (op)
      0: begin x = longint'(int'(a)); y = longint'(int'(b)); res = x * y; end
      1: begin ux = a; uy = b; res = ux * uy; end
      2: if (b != 0) begin
           x = longint'(int'(a)); y = longint'(int'(b));
           qs = x / y; rs = x % y;
           res = {rs[31:0], qs[31:0]};
         end
      3: if (b != 0) res = {a % b, a / b};
      4: res = {a, clo};
      5: res = {chi, b};
      default: ;
    endcase
    return res;
  endfunction

  task automatic issue(int op, logic [31:0] rs, logic [31:0] rt, string name);
    exp_t        e;
    logic [63:0] r;
    bus.start  = 1'b1;
    bus.op     = 3'(op);
    bus.rs_val = rs;
    bus.rt_val = rt;
    if (op <= 5) begin
      r = ref_md(op, rs, rt, m_hi, m_lo);
      if (op == 5) r = ref_md(5, rs, rs, m_hi, m_lo);
      m_hi = r[63:32];
      m_lo = r[31:0];
      e.hi = m_hi; e.lo = m_lo; e.name = name;
      e.cyc = (op <= 1) ? MC : (op <= 3) ? DC : 0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.busy) begin
      checks++;
      $display("FAIL busy_timeout: got busy=1, expected busy=0 within 200 cycles");
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: watches accepted requests and checks each commit against the queue.
  initial begin : monitor
    bit          in_flight = 0;
    bit          mt_pending = 0;
    int unsigned cnt = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_flight  = 0;
        mt_pending = 0;
      end else begin
        if (mt_pending) begin
          mt_pending = 0;
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL sb_underflow: got empty queue, expected an entry");
          end else begin
            e = sb.pop_front();
            chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
            chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
            chk({e.name, "_busy"}, 64'(bus.busy), 64'(0));
          end
        end
        if (in_flight) begin
          if (bus.busy) cnt++;
          else begin
            in_flight = 0;
            if (sb.size() == 0) begin
              checks++;
              $display("FAIL sb_underflow: got empty queue, expected an entry");
            end else begin
              e = sb.pop_front();
              chk({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
              chk({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
              chk({e.name, "_cycles"}, 64'(cnt), 64'(e.cyc));
            end
          end
        end
        if (bus.start && !bus.busy) begin
          if (bus.op == 3'd4 || bus.op == 3'd5) mt_pending = 1;
          else if (bus.op <= 3'd3) begin
            in_flight = 1;
            cnt = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_hi", 64'(bus.hi), 64'(0));
    chk("reset_lo", 64'(bus.lo), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    issue(4, 32'h1234_5678, 32'h0, "mthi");
    issue(5, 32'hCAFE_BABE, 32'h0, "mtlo");

    issue(0, 32'hFFFF_FFFE, 32'd3, "mult_neg");   wait_idle();
    issue(1, 32'hFFFF_FFFE, 32'd3, "multu");      wait_idle();
    issue(2, 32'hFFFF_FFF9, 32'd2, "div_neg");    wait_idle();
    issue(3, 32'd7, 32'd2, "divu");               wait_idle();

    issue(4, 32'hAAAA_0000, 32'h0, "mthi_pre");
    issue(5, 32'h0000_BBBB, 32'h0, "mtlo_pre");
    issue(2, 32'h1234_5678, 32'h0, "div_by_zero"); wait_idle();
    issue(2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"); wait_idle();

    issue(0, 32'd6, 32'd7, "mult_6x7");
    bus.start = 1'b1; bus.op = 3'd5; bus.rs_val = 32'h1; bus.rt_val = 32'h9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.rs_val = 32'hDEAD_BEEF; bus.rt_val = 32'h0BAD_F00D;
    @(posedge clk); #1;
    bus.rs_val = 32'h5555_AAAA; bus.rt_val = 32'hFFFF_0001;
    wait_idle();
    issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_b2b"); wait_idle();

    for (int i = 0; i < 40; i++) begin
      int op;
      op = $urandom_range(0, 7);
      issue(op, rnd_val(), rnd_val(), $sformatf("rnd%0d_op%0d", i, op));
      wait_idle();
    end

    issue(0, 32'h0001_0000, 32'h0001_0000, "mult_abort");
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_hi", 64'(bus.hi), 64'(0));
    chk("abort_lo", 64'(bus.lo), 64'(0));
    void'(sb.pop_back());
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    issue(4, 32'h0BAD_CAFE, 32'h0, "mthi_after_reset");

    repeat (DC + 3) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits in the EX stage, downstream of decode/operand forwarding, alongside the ALU.
- Handles MULT/MULTU/DIV/DIVU/MTHI/MTLO and provides HI/LO for MFHI/MFLO.
- Its busy flag drives the hazard unit's stall of HI/LO-dependent instructions.

Parameters:
MULT_CYCLES, 5, busy duration of MULT/MULTU in cycles (>=1)
DIV_CYCLES, 10, busy duration of DIV/DIVU in cycles (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  EX-stage instruction is a muldiv op, valid this cycle
op  input  3  operation code (md_defs encodings)
rs_val  input  32  forwarded rs operand
rt_val  input  32  forwarded rt operand
busy  output  1  registered; high while a multiply/divide is in flight
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (reset==0, asynchronous): hi=0, lo=0, busy=0, counter=0, latched operands=0. Reset mid-operation aborts it; no partial result is written.
- op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5. Codes 6 and 7 are no-ops.
- Accept rule: start is accepted only when busy==0. start while busy==1 is ignored with no state change; the hazard unit guarantees this never happens in legal flow.
- MTHI/MTLO (accepted): hi<=rs_val or lo<=rs_val at the next edge. Single cycle; busy stays 0.
- MULT/MULTU/DIV/DIVU (accepted):
  - latch rs_val, rt_val and op
  - counter<=MULT_CYCLES or DIV_CYCLES
  - busy rises at the same edge
- While counter>1: counter decrements each edge.
- At the edge where counter==1:
  - hi/lo written from the latched operands
  - counter<=0, busy<=0
  - new hi/lo are visible in the cycle busy is first low
- Latency: busy high for exactly N cycles; results readable N cycles after the start edge.
- Back-to-back: a new start may be accepted in the first cycle busy==0.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64 product.
  - MULTU: {hi,lo} = unsigned product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (DIV/DIVU with rt==0): full busy period runs, hi and lo left unchanged.
- Operands are sampled only at the accept edge; later changes on rs_val/rt_val during busy have no effect.
- hi/lo outputs always reflect committed register contents. No bypass of in-flight results.

Decomposition:
- Package md_defs:
  - op encodings MD_MULT..MD_MTLO, width MD_OP_W=3
  - default cycle counts
  - localparam for 32/64-bit widths
- One natural sub-module, md_calc: purely combinational. Takes latched op, a and b; produces 64-bit {hi_next, lo_next} plus a div_by_zero flag.
- md_unit owns the counter, latches, HI/LO registers and accept logic.

Test Plan:
- Reset then MTHI rs=0x12345678, then MTLO rs=0xCAFEBABE -> hi=0x12345678, lo=0xCAFEBABE, busy never asserted.
- MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV rs=0xFFFFFFF9(-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
- DIV rt=0 with prior hi=0xAAAA0000, lo=0x0000BBBB -> busy 10 cycles, hi/lo unchanged. Separately, DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT 6x7, with start pulsed with MTLO 0x1 and rs/rt toggling mid-busy -> extra start ignored; final lo=42, hi=0. New MULT accepted in first busy-low cycle.
- MULT in flight, then reset driven 0 at cycle 3 -> busy=0, hi=lo=0 immediately (asynchronous). After release, MTHI works normally.
